kmc_intr: RTL and testbench
===========================

Name: kmc_intr

Overview:
- Interrupt request controller sitting directly downstream of the KMC11 MISC register.
- Consumes the edge-triggered interrupt trigger (kmcSETIRQ) and the vector select bit (kmcVECTXXX4) produced by MISC.
- Drives the KS10 bus interrupt request/vector handshake.
- Returns the active-request status (kmcIRQO) to MISC bit 7.
- Buffers one additional request so that back-to-back microcode triggers are not lost.

Parameters:
- VECT, 9'o540: base interrupt vector. Bit 2 of the output vector is replaced by the captured VECTXXX4 (540 or 544).
- BRLEVEL, 3'd5: bus request priority level, legal range 4..7. Selects which bit of devINTR is driven.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- kmcINIT  in  1  device initialize; same effect as rst
- kmcSETIRQ  in  1  one-cycle trigger from MISC (write with bit 7 set)
- kmcVECTXXX4  in  1  vector select; sampled in the same cycle as kmcSETIRQ
- devIACK  in  1  one-cycle interrupt acknowledge from the bus arbiter
- devINTR  out  4  bus request, indexed [7:4]; only bit BRLEVEL may be set
- devVECT  out  9  interrupt vector, valid while devINTR is non-zero
- kmcIRQO  out  1  request active or pending; feeds MISC bit 7
- kmcOVFL  out  1  sticky: a trigger was dropped because both slots were full

Behaviour:
- Reset (rst or kmcINIT, synchronous, rst has priority):
  - state=IDLE; both slots invalid.
  - devINTR=0, devVECT=0, kmcIRQO=0, kmcOVFL=0.
  - Reset asserted mid-handshake discards the active and pending requests; devINTR drops on the next edge.
- Storage:
  - Active slot: valid bit plus captured VECTXXX4.
  - Pending slot: valid bit plus captured VECTXXX4.
  - Captured vector = VECT with bit 2 replaced by VECTXXX4 at trigger time. A later change of VECTXXX4 does not alter a stored request.
- States:
  - IDLE: no active request.
    - kmcSETIRQ: load active slot, go to REQ. devINTR[BRLEVEL] is high from the next cycle, i.e. 1-cycle latency.
  - REQ: devINTR[BRLEVEL]=1, devVECT = active vector, held stable.
    - devIACK: retire active slot.
      - If pending valid (or kmcSETIRQ in the same cycle), go to GAP.
      - Otherwise go to IDLE.
  - GAP: exactly one cycle with devINTR=0, so the arbiter sees a fresh request.
    - Promote pending to active, go to REQ.
- Trigger while the active slot is busy (REQ or GAP):
  - Load the pending slot if it is empty.
  - If the pending slot is full, drop the trigger and set kmcOVFL. kmcOVFL clears only on rst/kmcINIT.
- Simultaneous kmcSETIRQ and devIACK in REQ:
  - Pending empty: the new trigger goes to the pending slot, then GAP, then REQ with the new vector.
  - Pending full: promote the existing pending entry; the new trigger becomes pending; no overflow.
- Simultaneous kmcSETIRQ during GAP:
  - Promotion happens; the trigger loads the freed pending slot.
- devIACK in IDLE or GAP is ignored; no state change.
- kmcIRQO = active valid OR pending valid, registered, so it is high the cycle after the trigger.
- devVECT = 0 whenever devINTR = 0.

Decomposition:
- Shared KMC package (alongside the existing MISC/CRAM definitions) holds:
  - the state enum {IDLE, REQ, GAP};
  - the default vector 9'o540;
  - the default BR level 5;
  - the vector-bit-2 position constant.
- No sub-module. The two slots are a two-entry register pair and stay inline.

Test Plan:
- Single trigger: kmcSETIRQ with kmcVECTXXX4=0 at cycle 0 -> devINTR=4'b0010 (bit 5) and devVECT=9'o540 from cycle 1; kmcIRQO=1. devIACK at cycle 5 -> devINTR=0 and kmcIRQO=0 at cycle 6.
- Vector capture: trigger with VECTXXX4=1, then VECTXXX4 driven 0 the next cycle -> devVECT stays 9'o544 until devIACK.
- Back-to-back: trigger (XXX4=0), then trigger (XXX4=1) two cycles later, then devIACK -> one cycle of devINTR=0 (GAP), then REQ with devVECT=9'o544. Second devIACK -> IDLE; kmcOVFL=0.
- Overflow: three triggers with no devIACK -> kmcOVFL=1. Two devIACKs drain exactly two vectors (540, then 544); the third trigger is never presented.
- Same-cycle trigger and devIACK with pending full -> pending promoted, new trigger becomes pending; kmcOVFL stays 0; three vectors delivered in order.
- Reset mid-operation: kmcINIT pulse while in REQ with pending full -> next cycle devINTR=0, kmcIRQO=0, kmcOVFL=0. A following devIACK is ignored.

Source files
------------

// File: rtl/kmc_intr_pkg.sv
// Shared KMC definitions used by the interrupt controller: state encoding,
// default vector/priority and the slot layout.
package kmc_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic x4;
  } slot_t;

  localparam logic [8:0] KMC_VECT_DEFAULT    = 9'o540;
  localparam int         KMC_BRLEVEL_DEFAULT = 5;
  localparam int         KMC_VECT_X4_BIT     = 2;

  // Builds the bus vector from the base vector and the captured select bit.
  function automatic logic [8:0] makeVect(input logic [8:0] base, input logic x4);
    logic [8:0] v;
    v = base;
    v[KMC_VECT_X4_BIT] = x4;
    return v;
  endfunction

endpackage

// File: rtl/kmc_intr_if.sv
// MISC-side trigger inputs and KS10 bus interrupt handshake for kmc_intr.
interface kmc_intr_if;

  logic       kmcINIT;
  logic       kmcSETIRQ;
  logic       kmcVECTXXX4;
  logic       devIACK;
  logic [7:4] devINTR;
  logic [8:0] devVECT;
  logic       kmcIRQO;
  logic       kmcOVFL;

  modport master (
    output kmcINIT, kmcSETIRQ, kmcVECTXXX4, devIACK,
    input  devINTR, devVECT, kmcIRQO, kmcOVFL
  );

  modport slave (
    input  kmcINIT, kmcSETIRQ, kmcVECTXXX4, devIACK,
    output devINTR, devVECT, kmcIRQO, kmcOVFL
  );

endinterface

// File: rtl/kmc_intr.sv
// KMC11 interrupt request controller: turns MISC trigger pulses into a
// KS10 bus request/vector handshake with one request of buffering.
module kmc_intr
  import kmc_intr_pkg::*;
#(
  parameter logic [8:0] VECT    = KMC_VECT_DEFAULT,
  parameter int         BRLEVEL = KMC_BRLEVEL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  kmc_intr_if.slave  bus
);

  state_t r_state, w_stateNext;
  slot_t  r_act, w_actNext;
  slot_t  r_pend, w_pendNext;
  slot_t  w_newSlot;
  logic   r_ovfl, w_ovflNext;
  logic   r_irqo;

  assign w_newSlot = {1'b1, bus.kmcVECTXXX4};

  // State, slot and status registers; rst and kmcINIT both clear everything.
  always_ff @(posedge clk) begin
    if (rst || bus.kmcINIT) begin
      r_state <= ST_IDLE;
      r_act   <= '0;
      r_pend  <= '0;
      r_ovfl  <= 1'b0;
      r_irqo  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_act   <= w_actNext;
      r_pend  <= w_pendNext;
      r_ovfl  <= w_ovflNext;
      r_irqo  <= w_actNext.valid | w_pendNext.valid;
    end
  end

  // Next-state and slot bookkeeping; the entry due next is moved into the
  // active slot at acknowledge time so GAP only has to wait one cycle.
  always_comb begin
    w_stateNext = r_state;
    w_actNext   = r_act;
    w_pendNext  = r_pend;
    w_ovflNext  = r_ovfl;
    case (r_state)
      ST_IDLE: begin
        if (bus.kmcSETIRQ) begin
          w_actNext   = w_newSlot;
          w_stateNext = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.devIACK) begin
          if (r_pend.valid) begin
            w_actNext   = r_pend;
            w_pendNext  = bus.kmcSETIRQ ? w_newSlot : slot_t'('0);
            w_stateNext = ST_GAP;
          end else if (bus.kmcSETIRQ) begin
            w_actNext   = w_newSlot;
            w_stateNext = ST_GAP;
          end else begin
            w_actNext   = '0;
            w_stateNext = ST_IDLE;
          end
        end else if (bus.kmcSETIRQ) begin
          if (!r_pend.valid) w_pendNext = w_newSlot;
          else               w_ovflNext = 1'b1;
        end
      end
      ST_GAP: begin
        w_stateNext = ST_REQ;
        if (bus.kmcSETIRQ) begin
          if (!r_pend.valid) w_pendNext = w_newSlot;
          else               w_ovflNext = 1'b1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_actNext   = '0;
        w_pendNext  = '0;
      end
    endcase
  end

  // Bus request and vector are only presented while in REQ.
  always_comb begin
    bus.devINTR = '0;
    bus.devVECT = '0;
    if (r_state == ST_REQ) begin
      bus.devINTR[BRLEVEL] = 1'b1;
      bus.devVECT          = makeVect(VECT, r_act.x4);
    end
  end

  assign bus.kmcIRQO = r_irqo;
  assign bus.kmcOVFL = r_ovfl;

endmodule

// File: tb/tb_kmc_intr.sv
// Directed self-checking bench for kmc_intr.
module tb_kmc_intr;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  localparam logic [3:0] INTR_ON  = 4'b0010;
  localparam logic [3:0] INTR_OFF = 4'b0000;
  localparam logic [8:0] V540     = 9'o540;
  localparam logic [8:0] V544     = 9'o544;

  kmc_intr_if bus ();

  kmc_intr dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, then returns just after the edge with all
  // pulses cleared so outputs can be sampled.
  task automatic applyStimulus(input logic setirq, input logic x4,
                               input logic iack, input logic init);
    bus.kmcSETIRQ   = setirq;
    bus.kmcVECTXXX4 = x4;
    bus.devIACK     = iack;
    bus.kmcINIT     = init;
    @(posedge clk);
    #1;
    bus.kmcSETIRQ   = 1'b0;
    bus.kmcVECTXXX4 = 1'b0;
    bus.devIACK     = 1'b0;
    bus.kmcINIT     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL reset_intr got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.devVECT !== 9'o0) begin errors++; $display("FAIL reset_vect got %o exp 0", bus.devVECT); end
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL reset_irqo got %b exp 0", bus.kmcIRQO); end
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL reset_ovfl got %b exp 0", bus.kmcOVFL); end
  endtask

  task automatic test_idle_iack();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL idle_iack_intr got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL idle_iack_irqo got %b exp 0", bus.kmcIRQO); end
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devINTR !== INTR_ON) begin errors++; $display("FAIL single_intr got %b exp %b", bus.devINTR, INTR_ON); end
    checks++; if (bus.devVECT !== V540) begin errors++; $display("FAIL single_vect got %o exp %o", bus.devVECT, V540); end
    checks++; if (bus.kmcIRQO !== 1'b1) begin errors++; $display("FAIL single_irqo got %b exp 1", bus.kmcIRQO); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devINTR !== INTR_ON) begin errors++; $display("FAIL single_hold got %b exp %b", bus.devINTR, INTR_ON); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL single_ack_intr got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.devVECT !== 9'o0) begin errors++; $display("FAIL single_ack_vect got %o exp 0", bus.devVECT); end
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL single_ack_irqo got %b exp 0", bus.kmcIRQO); end
  endtask

  task automatic test_vector_capture();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    bus.kmcVECTXXX4 = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devVECT !== V544) begin errors++; $display("FAIL capture_vect got %o exp %o", bus.devVECT, V544); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devVECT !== V544) begin errors++; $display("FAIL capture_hold got %o exp %o", bus.devVECT, V544); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL capture_ack got %b exp %b", bus.devINTR, INTR_OFF); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.devVECT !== V540) begin errors++; $display("FAIL b2b_first got %o exp %o", bus.devVECT, V540); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL b2b_gap_intr got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.devVECT !== 9'o0) begin errors++; $display("FAIL b2b_gap_vect got %o exp 0", bus.devVECT); end
    checks++; if (bus.kmcIRQO !== 1'b1) begin errors++; $display("FAIL b2b_gap_irqo got %b exp 1", bus.kmcIRQO); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devINTR !== INTR_ON) begin errors++; $display("FAIL b2b_second_intr got %b exp %b", bus.devINTR, INTR_ON); end
    checks++; if (bus.devVECT !== V544) begin errors++; $display("FAIL b2b_second_vect got %o exp %o", bus.devVECT, V544); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL b2b_done_irqo got %b exp 0", bus.kmcIRQO); end
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL b2b_ovfl got %b exp 0", bus.kmcOVFL); end
  endtask

  task automatic test_overflow();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL ovfl_early got %b exp 0", bus.kmcOVFL); end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.kmcOVFL !== 1'b1) begin errors++; $display("FAIL ovfl_set got %b exp 1", bus.kmcOVFL); end
    checks++; if (bus.devVECT !== V540) begin errors++; $display("FAIL ovfl_first got %o exp %o", bus.devVECT, V540); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devVECT !== V544) begin errors++; $display("FAIL ovfl_second got %o exp %o", bus.devVECT, V544); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL ovfl_no_third got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL ovfl_drained_irqo got %b exp 0", bus.kmcIRQO); end
    checks++; if (bus.kmcOVFL !== 1'b1) begin errors++; $display("FAIL ovfl_sticky got %b exp 1", bus.kmcOVFL); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL ovfl_init_clear got %b exp 0", bus.kmcOVFL); end
  endtask

  task automatic test_same_cycle_full();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL same_gap got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL same_ovfl got %b exp 0", bus.kmcOVFL); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devVECT !== V544) begin errors++; $display("FAIL same_second got %o exp %o", bus.devVECT, V544); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devVECT !== V540) begin errors++; $display("FAIL same_third got %o exp %o", bus.devVECT, V540); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL same_done_irqo got %b exp 0", bus.kmcIRQO); end
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL same_done_ovfl got %b exp 0", bus.kmcOVFL); end
  endtask

  task automatic test_gap_trigger();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.devVECT !== V544) begin errors++; $display("FAIL gap_promote got %o exp %o", bus.devVECT, V544); end
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL gap_ovfl got %b exp 0", bus.kmcOVFL); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devVECT !== V540) begin errors++; $display("FAIL gap_loaded got %o exp %o", bus.devVECT, V540); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL gap_done_irqo got %b exp 0", bus.kmcIRQO); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.kmcOVFL !== 1'b1) begin errors++; $display("FAIL mid_pre_ovfl got %b exp 1", bus.kmcOVFL); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL mid_intr got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL mid_irqo got %b exp 0", bus.kmcIRQO); end
    checks++; if (bus.kmcOVFL !== 1'b0) begin errors++; $display("FAIL mid_ovfl got %b exp 0", bus.kmcOVFL); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.devINTR !== INTR_OFF) begin errors++; $display("FAIL mid_after_iack got %b exp %b", bus.devINTR, INTR_OFF); end
    checks++; if (bus.kmcIRQO !== 1'b0) begin errors++; $display("FAIL mid_after_irqo got %b exp 0", bus.kmcIRQO); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.kmcINIT     = 1'b0;
    bus.kmcSETIRQ   = 1'b0;
    bus.kmcVECTXXX4 = 1'b0;
    bus.devIACK     = 1'b0;
    test_reset();
    test_idle_iack();
    test_single();
    test_vector_capture();
    test_back_to_back();
    test_overflow();
    test_same_cycle_full();
    test_gap_trigger();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
